// File: rtl/operand_loader.sv
// Input stage for the prefix adder: synchronizes and debounces the board inputs,
// captures the X/Y/carry operands and tracks operand validity for a valid/ack consumer.
module operand_loader #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_n,
  input  logic             sel,
  input  logic [WIDTH-1:0] data_in,
  input  logic             carry_sw,
  input  logic             ack,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic             cin_out,
  output logic             x_valid,
  output logic             y_valid,
  output logic             operands_ready,
  output logic             load_strobe
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {EMPTY, HAVE_X, HAVE_Y, READY} state_t;

  logic [SYNC_STAGES-1:0] key_sync;
  logic [SYNC_STAGES-1:0] sel_sync;
  logic [SYNC_STAGES-1:0] carry_sync;
  logic [WIDTH-1:0]       data_sync [SYNC_STAGES];

  logic             key_s;
  logic             sel_s;
  logic             carry_s;
  logic [WIDTH-1:0] data_s;

  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] counter;

  logic   press;
  logic   load_x;
  logic   load_y;
  state_t state;
  state_t state_next;

  // Synchronizer chains; the key chain idles at released (1)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_sync   <= '1;
      sel_sync   <= '0;
      carry_sync <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) data_sync[i] <= '0;
    end else begin
      key_sync   <= {key_sync[SYNC_STAGES-2:0], key_n};
      sel_sync   <= {sel_sync[SYNC_STAGES-2:0], sel};
      carry_sync <= {carry_sync[SYNC_STAGES-2:0], carry_sw};
      data_sync[0] <= data_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) data_sync[i] <= data_sync[i-1];
    end
  end

  assign key_s   = key_sync[SYNC_STAGES-1];
  assign sel_s   = sel_sync[SYNC_STAGES-1];
  assign carry_s = carry_sync[SYNC_STAGES-1];
  assign data_s  = data_sync[SYNC_STAGES-1];

  // Debouncer: a change is accepted after DEBOUNCE_CYCLES consecutive mismatching cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable   <= 1'b1;
      stable_d <= 1'b1;
      counter  <= '0;
    end else begin
      stable_d <= stable;
      if (key_s != stable) begin
        if (counter == CNT_MAX) begin
          stable  <= key_s;
          counter <= '0;
        end else begin
          counter <= counter + CNT_W'(1);
        end
      end else begin
        counter <= '0;
      end
    end
  end

  assign press  = stable_d & ~stable;
  assign load_x = press & sel_s;
  assign load_y = press & ~sel_s;

  // Operand capture; values persist across ack
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_out       <= '0;
      y_out       <= '0;
      cin_out     <= 1'b0;
      load_strobe <= 1'b0;
    end else begin
      load_strobe <= press;
      if (load_x) x_out <= data_s;
      if (load_y) y_out <= data_s;
      if (press)  cin_out <= carry_s;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // ack clears first, so a coincident load leaves only that operand valid
  always_comb begin
    state_next = state;
    if (ack) begin
      if (load_x)      state_next = HAVE_X;
      else if (load_y) state_next = HAVE_Y;
      else             state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (load_x)      state_next = HAVE_X;
          else if (load_y) state_next = HAVE_Y;
        end
        HAVE_X:  if (load_y) state_next = READY;
        HAVE_Y:  if (load_x) state_next = READY;
        READY:   state_next = READY;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    x_valid        = 1'b0;
    y_valid        = 1'b0;
    operands_ready = 1'b0;
    unique case (state)
      HAVE_X: x_valid = 1'b1;
      HAVE_Y: y_valid = 1'b1;
      READY: begin
        x_valid        = 1'b1;
        y_valid        = 1'b1;
        operands_ready = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/operand_loader.md
# operand_loader

Upstream input stage for the prefix adder datapath. Turns raw board inputs into clean, synchronized operands for the adder:
- a raw active-low load button;
- an 8-bit data switch bank;
- an operand-select switch and a carry switch.

It synchronizes and debounces these inputs, captures the X, Y and carry-in operands, and tracks which operands are valid. A valid/ack handshake tells the consumer when a complete operand set is ready.

## Interface
- WIDTH, 8: operand width.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles before a button change is accepted (10 ms at 50 MHz); minimum 2.
- SYNC_STAGES, 2: synchronizer depth for all asynchronous inputs; minimum 2.

- clock  in  1  system clock (board 50 MHz).
- reset  in  1  asynchronous, active-high; clears all state immediately.
- key_n  in  1  raw load button, active-low, asynchronous, bouncy.
- sel  in  1  raw operand select; 1 = X, 0 = Y.
- data_in  in  WIDTH  raw operand switches.
- carry_sw  in  1  raw carry-in switch.
- x_out  out  WIDTH  captured X operand.
- y_out  out  WIDTH  captured Y operand.
- cin_out  out  1  captured carry-in.
- x_valid  out  1  X captured since last ack.
- y_valid  out  1  Y captured since last ack.
- operands_ready  out  1  x_valid & y_valid.
- load_strobe  out  1  one-cycle pulse per accepted press.
- ack  in  1  synchronous; consumer has taken the operand set; clears both valids.

## Operation
- Synchronizers:
  - key_n, sel, data_in and carry_sw each pass through SYNC_STAGES flops.
  - key flops reset to 1 (released); all other flops reset to 0.
- Debouncer: state `stable` (reset 1) plus a counter (reset 0).
  - Each cycle synchronized key ≠ stable: counter increments.
  - When it equals DEBOUNCE_CYCLES-1 with a mismatch still present: stable <= synchronized key, counter <= 0.
  - Any cycle with key == stable: counter <= 0.
- Press event: the edge where stable goes 1→0. Release (0→1) produces no event.
- On a press event:
  - if synchronized sel = 1, x_out <= synchronized data_in;
  - if synchronized sel = 0, y_out <= synchronized data_in;
  - cin_out <= synchronized carry_sw on every press;
  - load_strobe is high for the following single cycle.
- FSM states:
  - EMPTY: loading X → HAVE_X; loading Y → HAVE_Y.
  - HAVE_X: loading X → HAVE_X, value overwritten; loading Y → READY.
  - HAVE_Y: loading Y → HAVE_Y, value overwritten; loading X → READY.
  - READY: any load overwrites the operand and stays READY; ack → EMPTY.
  - ack in a non-READY state clears the valids → EMPTY.
- Simultaneous ack and load on the same edge: ack clears first, then the loaded operand's valid is set. Next state is HAVE_X or HAVE_Y.
- x_out, y_out and cin_out hold their values across ack; only valids clear.
- Outputs: x_valid/y_valid decode from the state; operands_ready = (state == READY).

## Timing
- Reset values: x_out 0, y_out 0, cin_out 0, x_valid 0, y_valid 0, operands_ready 0, load_strobe 0. State EMPTY, counter 0, stable 1.
- Press latency: key_n held low from before edge 0. The capture edge is edge SYNC_STAGES + DEBOUNCE_CYCLES. load_strobe is high for the cycle after that edge.
- Data/sel/carry used at capture are the synchronized values at the capture edge. Switches must be steady for SYNC_STAGES cycles before that edge.
- A glitch held for fewer than DEBOUNCE_CYCLES consecutive cycles after synchronization changes nothing.
- A button held indefinitely yields exactly one press event.
- ack acts on the edge where it is sampled high; operands_ready falls the cycle after.
- Reset mid-debounce: counter and stable return to reset values; no capture is pending afterwards.
- A key still held low after reset release counts as a new press, captured SYNC_STAGES + DEBOUNCE_CYCLES edges after release.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, SYNC_STAGES=2.

1. Assert reset with random inputs → all outputs 0 immediately (asynchronous), and still 0 after two clocks.
2. Load X: sel=1, data_in=0x5A, key_n low for 10 cycles → x_out=0x5A at edge 6, single load_strobe, x_valid=1, operands_ready=0. Release → no second strobe.
3. Load Y then ack: sel=0, data_in=0xA5, carry_sw=1, press → y_out=0xA5, cin_out=1, operands_ready=1. One-cycle ack → all valids 0; x_out=0x5A and y_out=0xA5 retained.
4. Bounce rejection: key_n low 3 cycles, high 1, low 3, high → no capture. Then low 6 cycles → exactly one strobe.
5. Simultaneous events: in READY, ack coincides with an X capture of 0x33 → x_out=0x33, x_valid=1, y_valid=0, operands_ready=0.
6. Reset mid-debounce: key_n low, reset after 3 cycles for 2 cycles with key still low → no capture during reset. Capture at edge 6 after reset release.
